inst_fetch_decode: RTL and testbench

Front-end stage that feeds the ALU. Fetches instruction bytes from an 8-bit-wide synchronous instruction memory, decodes the supported opcode subset (0x55, 0x89, 0xb8, 0x5d, 0xc3, 0xe8), and assembles each instruction's length, ModR/M byte and little-endian 32-bit immediate. Each complete instruction is presented on `ope` / `immidiate_data` with a valid/ready handshake. It accepts a PC redirect from downstream for `call` and `ret`.

---
 rtl/inst_fetch_decode.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_decode.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode front end: pulls opcode, ModR/M and imm32 bytes from
// an 8-bit synchronous memory and issues one decoded instruction per handshake.
module inst_fetch_decode #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [7:0]  mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   output logic [31:0] ope,
   output logic [31:0] immidiate_data,
   output logic [7:0]  modrm,
   output logic [2:0]  inst_len,
   output logic [7:0]  pc_out,
   output logic [7:0]  next_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic        illegal
);

   typedef enum logic [2:0] {
      OP_REQ, OP_CAP, MRM_REQ, MRM_CAP, IMM_REQ, IMM_CAP, ISSUE, HALT
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  op_q, op_d;
   logic [7:0]  modrm_q, modrm_d;
   logic [31:0] imm_q, imm_d;
   logic [2:0]  len_q, len_d;
   logic [7:0]  pc_out_q, pc_out_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      op_d     = op_q;
      modrm_d  = modrm_q;
      imm_d    = imm_q;
      len_d    = len_q;
      pc_out_d = pc_out_q;
      cnt_d    = cnt_q;
      case (state_q)
         OP_REQ: state_d = OP_CAP;
         OP_CAP: begin
            op_d     = mem_data;
            pc_d     = pc_q + 8'd1;
            pc_out_d = pc_q;
            case (mem_data)
               8'h55, 8'h5d, 8'hc3: begin
                  len_d   = 3'd1;
                  state_d = ISSUE;
               end
               8'h89: begin
                  len_d   = 3'd2;
                  state_d = MRM_REQ;
               end
               8'hb8, 8'he8: begin
                  len_d   = 3'd5;
                  cnt_d   = 2'd0;
                  state_d = IMM_REQ;
               end
               default: begin
                  len_d   = 3'd0;
                  state_d = HALT;
               end
            endcase
         end
         MRM_REQ: state_d = MRM_CAP;
         MRM_CAP: begin
            modrm_d = mem_data;
            pc_d    = pc_q + 8'd1;
            state_d = ISSUE;
         end
         IMM_REQ: state_d = IMM_CAP;
         IMM_CAP: begin
            // Bytes arrive least-significant first.
            imm_d[{cnt_q, 3'b000} +: 8] = mem_data;
            pc_d    = pc_q + 8'd1;
            cnt_d   = cnt_q + 2'd1;
            state_d = (cnt_q == 2'd3) ? ISSUE : IMM_REQ;
         end
         ISSUE: begin
            if (dec_ready) begin
               imm_d   = '0;
               modrm_d = '0;
               state_d = OP_REQ;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = OP_REQ;
      endcase
      // Redirect discards any byte still in flight by never entering a capture state for it.
      if (redirect) begin
         pc_d     = redirect_pc;
         op_d     = op_q;
         len_d    = len_q;
         pc_out_d = pc_out_q;
         imm_d    = '0;
         modrm_d  = '0;
         cnt_d    = 2'd0;
         state_d  = OP_REQ;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= OP_REQ;
         pc_q     <= RESET_PC;
         op_q     <= '0;
         modrm_q  <= '0;
         imm_q    <= '0;
         len_q    <= '0;
         pc_out_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         op_q     <= op_d;
         modrm_q  <= modrm_d;
         imm_q    <= imm_d;
         len_q    <= len_d;
         pc_out_q <= pc_out_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mem_rd         = reset_n && (state_q == OP_REQ || state_q == MRM_REQ || state_q == IMM_REQ);
   assign mem_addr       = reset_n ? pc_q : RESET_PC;
   assign ope            = {24'h000000, op_q};
   assign immidiate_data = imm_q;
   assign modrm          = modrm_q;
   assign inst_len       = len_q;
   assign pc_out         = pc_out_q;
   assign next_pc        = pc_out_q + {5'b00000, len_q};
   assign dec_valid      = (state_q == ISSUE);
   assign illegal        = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Bench for inst_fetch_decode: directed timing scenarios plus a randomized
// instruction stream checked against a table-driven decoder of memory contents.
module tb_inst_fetch_decode;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data = 8'h00;
   logic [31:0] ope, immidiate_data;
   logic [7:0]  modrm, pc_out, next_pc;
   logic [2:0]  inst_len;
   logic        dec_valid, illegal;
   logic        dec_ready = 1'b1;
   logic        redirect = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;

   logic [7:0]  mem [256];
   int          vectors = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [90:0] dec_bus;

   inst_fetch_decode #(.RESET_PC(8'h00)) u_dut (
      .clock(clock), .reset_n(reset_n), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .ope(ope), .immidiate_data(immidiate_data), .modrm(modrm),
      .inst_len(inst_len), .pc_out(pc_out), .next_pc(next_pc), .dec_valid(dec_valid),
      .dec_ready(dec_ready), .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal)
   );

   always #5 clock = ~clock;

   // Synchronous instruction memory: data appears the cycle after the read strobe.
   always @(posedge clock) if (mem_rd) mem_data <= mem[mem_addr];

   assign dec_bus = {ope, immidiate_data, modrm, inst_len, pc_out, next_pc};

   // Decoded view of the instruction starting at pc, straight from the opcode table.
   function automatic logic [90:0] ref_bus(input logic [7:0] pc, output int len);
      logic [7:0]  op, mrm, nxt;
      logic [31:0] imm;
      op = mem[pc]; mrm = 8'h00; imm = 32'h0; len = 0;
      case (op)
         8'h55, 8'h5d, 8'hc3: len = 1;
         8'h89: begin len = 2; mrm = mem[8'(pc + 8'd1)]; end
         8'hb8, 8'he8: begin
            len = 5;
            imm = {mem[8'(pc + 8'd4)], mem[8'(pc + 8'd3)], mem[8'(pc + 8'd2)], mem[8'(pc + 8'd1)]};
         end
         default: len = 0;
      endcase
      nxt = pc + 8'(len);
      return {24'h0, op, imm, mrm, 3'(len), pc, nxt};
   endfunction

   task automatic tick();
      @(negedge clock);
      cyc++;
   endtask

   task automatic fill(input logic [7:0] b);
      for (int i = 0; i < 256; i++) mem[i] = b;
   endtask

   // Leaves reset_n just raised at the midpoint of cycle 0.
   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0; redirect = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      fill(8'h55);
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      vectors++; if ({ope, immidiate_data, modrm, inst_len, pc_out, next_pc, dec_valid, illegal} !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {ope, immidiate_data, modrm, inst_len, pc_out, next_pc, dec_valid, illegal}); end
      vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
      vectors++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
   endtask

   task automatic test_one_byte();
      fill(8'h55);
      dec_ready = 1'b1;
      apply_reset();
      #1;
      vectors++; if ({mem_rd, mem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL c0_fetch: got rd=%b addr=%h want rd=1 addr=00", mem_rd, mem_addr); end
      tick();
      vectors++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL c1_valid: got %b want 0", dec_valid); end
      tick();
      vectors++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL c2_valid: got %b want 1", dec_valid); end
      vectors++; if (dec_bus !== {32'h55, 32'h0, 8'h0, 3'd1, 8'h00, 8'h01}) begin errors++; $display("FAIL one_byte_fields: got ope=%h len=%0d pc=%h npc=%h", ope, inst_len, pc_out, next_pc); end
      tick();
      vectors++; if ({mem_rd, mem_addr, dec_valid} !== {1'b1, 8'h01, 1'b0}) begin errors++; $display("FAIL c3_fetch: got rd=%b addr=%h v=%b want rd=1 addr=01 v=0", mem_rd, mem_addr, dec_valid); end
   endtask

   task automatic test_imm();
      bit early = 0;
      fill(8'hc3);
      mem[0] = 8'hb8; mem[1] = 8'h78; mem[2] = 8'h56; mem[3] = 8'h34; mem[4] = 8'h12;
      dec_ready = 1'b1;
      apply_reset();
      while (cyc < 10) begin
         if (dec_valid) early = 1;
         tick();
      end
      vectors++; if (early) begin errors++; $display("FAIL imm_early_valid: got early valid want none before cycle 10"); end
      vectors++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL imm_c10_valid: got %b want 1", dec_valid); end
      vectors++; if (dec_bus !== {32'hb8, 32'h12345678, 8'h0, 3'd5, 8'h00, 8'h05}) begin errors++; $display("FAIL imm_fields: got ope=%h imm=%h len=%0d npc=%h", ope, immidiate_data, inst_len, next_pc); end
   endtask

   task automatic test_modrm();
      fill(8'h55);
      mem[0] = 8'h89; mem[1] = 8'he5; mem[2] = 8'h5d;
      dec_ready = 1'b1;
      apply_reset();
      repeat (4) tick();
      vectors++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL mrm_c4_valid: got %b want 1", dec_valid); end
      vectors++; if (dec_bus !== {32'h89, 32'h0, 8'he5, 3'd2, 8'h00, 8'h02}) begin errors++; $display("FAIL mrm_fields: got ope=%h modrm=%h imm=%h len=%0d", ope, modrm, immidiate_data, inst_len); end
      repeat (3) tick();
      vectors++; if ({dec_valid, dec_bus} !== {1'b1, 32'h5d, 32'h0, 8'h00, 3'd1, 8'h02, 8'h03}) begin errors++; $display("FAIL pop_fields: got v=%b ope=%h modrm=%h pc=%h", dec_valid, ope, modrm, pc_out); end
   endtask

   task automatic test_backpressure();
      logic [90:0] snap;
      fill(8'h55);
      mem[0] = 8'hc3;
      dec_ready = 1'b0;
      apply_reset();
      repeat (2) tick();
      snap = dec_bus;
      vectors++; if ({dec_valid, snap} !== {1'b1, 32'hc3, 32'h0, 8'h0, 3'd1, 8'h00, 8'h01}) begin errors++; $display("FAIL bp_first: got v=%b bus=%h", dec_valid, snap); end
      repeat (5) begin
         tick();
         vectors++; if ({dec_valid, mem_rd, dec_bus} !== {1'b1, 1'b0, snap}) begin errors++; $display("FAIL bp_hold: got v=%b rd=%b bus=%h want v=1 rd=0 bus=%h", dec_valid, mem_rd, dec_bus, snap); end
      end
      dec_ready = 1'b1;
      tick();
      vectors++; if ({dec_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 8'h01}) begin errors++; $display("FAIL bp_release: got v=%b rd=%b addr=%h want v=0 rd=1 addr=01", dec_valid, mem_rd, mem_addr); end
      repeat (2) tick();
      vectors++; if ({dec_valid, ope, pc_out, next_pc} !== {1'b1, 32'h55, 8'h01, 8'h02}) begin errors++; $display("FAIL bp_next: got v=%b ope=%h pc=%h npc=%h", dec_valid, ope, pc_out, next_pc); end
   endtask

   task automatic test_redirect();
      bit early = 0;
      fill(8'h55);
      mem[0] = 8'he8; mem[1] = 8'h10; mem[2] = 8'h20; mem[3] = 8'h30; mem[4] = 8'h40;
      mem[8'h40] = 8'hc3;
      dec_ready = 1'b1;
      apply_reset();
      while (cyc < 6) begin
         if (dec_valid) early = 1;
         tick();
      end
      vectors++; if ({early, mem_rd, mem_addr} !== {1'b0, 1'b1, 8'h03}) begin errors++; $display("FAIL rd_byte2_req: got early=%b rd=%b addr=%h want 0 1 03", early, mem_rd, mem_addr); end
      redirect = 1'b1; redirect_pc = 8'h40;
      tick();
      redirect = 1'b0;
      vectors++; if ({dec_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 8'h40}) begin errors++; $display("FAIL rd_target_fetch: got v=%b rd=%b addr=%h want 0 1 40", dec_valid, mem_rd, mem_addr); end
      tick();
      vectors++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rd_no_e8: got v=%b want 0", dec_valid); end
      tick();
      vectors++; if ({dec_valid, ope, pc_out, next_pc} !== {1'b1, 32'hc3, 8'h40, 8'h41}) begin errors++; $display("FAIL rd_issue: got v=%b ope=%h pc=%h npc=%h", dec_valid, ope, pc_out, next_pc); end
   endtask

   task automatic test_wrap_illegal();
      bit early = 0;
      fill(8'h55);
      mem[8'hff] = 8'hb8; mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
      mem[4] = 8'h90; mem[8'h40] = 8'hc3;
      dec_ready = 1'b1;
      apply_reset();
      redirect = 1'b1; redirect_pc = 8'hff;
      tick();
      redirect = 1'b0;
      vectors++; if ({mem_rd, mem_addr} !== {1'b1, 8'hff}) begin errors++; $display("FAIL wrap_fetch: got rd=%b addr=%h want 1 ff", mem_rd, mem_addr); end
      while (cyc < 11) begin
         if (dec_valid) early = 1;
         tick();
      end
      vectors++; if ({early, dec_valid} !== 2'b01) begin errors++; $display("FAIL wrap_valid: got early=%b v=%b want 0 1", early, dec_valid); end
      vectors++; if (dec_bus !== {32'hb8, 32'h04030201, 8'h0, 3'd5, 8'hff, 8'h04}) begin errors++; $display("FAIL wrap_fields: got imm=%h pc=%h npc=%h len=%0d", immidiate_data, pc_out, next_pc, inst_len); end
      repeat (2) tick();
      vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_early: got %b want 0 during opcode capture", illegal); end
      tick();
      repeat (4) begin
         vectors++; if ({illegal, dec_valid, mem_rd} !== 3'b100) begin errors++; $display("FAIL ill_halt: got ill=%b v=%b rd=%b want 1 0 0", illegal, dec_valid, mem_rd); end
         tick();
      end
      redirect = 1'b1; redirect_pc = 8'h40;
      tick();
      redirect = 1'b0;
      vectors++; if ({illegal, mem_rd, mem_addr} !== {1'b0, 1'b1, 8'h40}) begin errors++; $display("FAIL ill_exit: got ill=%b rd=%b addr=%h want 0 1 40", illegal, mem_rd, mem_addr); end
      repeat (2) tick();
      vectors++; if ({dec_valid, ope, pc_out} !== {1'b1, 32'hc3, 8'h40}) begin errors++; $display("FAIL ill_resume: got v=%b ope=%h pc=%h", dec_valid, ope, pc_out); end
   endtask

   task automatic test_random();
      logic [7:0]  opts [6] = '{8'h55, 8'h89, 8'hb8, 8'h5d, 8'hc3, 8'he8};
      logic [7:0]  starts [$];
      logic [7:0]  model_pc = 8'h00;
      logic [90:0] exp_bus;
      int          pos = 0, len, k, transfers = 0;
      bit          redir;
      while (pos < 240) begin
         starts.push_back(8'(pos));
         k = $urandom_range(0, 5);
         mem[pos] = opts[k];
         len = (opts[k] == 8'h89) ? 2 : (opts[k] == 8'hb8 || opts[k] == 8'he8) ? 5 : 1;
         for (int j = 1; j < len; j++) mem[pos + j] = 8'($urandom);
         pos += len;
      end
      for (int p = pos; p < 256; p++) begin
         mem[p] = 8'h55;
         starts.push_back(8'(p));
      end
      dec_ready = 1'b1;
      apply_reset();
      repeat (3000) begin
         tick();
         vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL rnd_illegal: got %b want 0 at cycle %0d", illegal, cyc); end
         if (dec_valid) begin
            exp_bus = ref_bus(model_pc, len);
            vectors++; if ({mem_rd, dec_bus} !== {1'b0, exp_bus}) begin errors++; $display("FAIL rnd_issue: cycle %0d got rd=%b bus=%h want rd=0 bus=%h", cyc, mem_rd, dec_bus, exp_bus); end
         end
         dec_ready = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 39) == 0);
         redirect = redir;
         if (redir) redirect_pc = starts[$urandom_range(0, starts.size() - 1)];
         if (dec_valid && dec_ready) begin
            void'(ref_bus(model_pc, len));
            model_pc = model_pc + 8'(len);
            transfers++;
         end
         if (redir) model_pc = redirect_pc;
      end
      redirect = 1'b0;
      vectors++; if (transfers < 150) begin errors++; $display("FAIL rnd_progress: got %0d transfers want at least 150", transfers); end
   endtask

   initial begin
      test_reset();
      test_one_byte();
      test_imm();
      test_modrm();
      test_backpressure();
      test_redirect();
      test_wrap_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
